// File: rtl/mult_cascade_pkg.sv
// mult_cascade_pkg: shared sizing and latency helpers for the cascaded
// multiplier chain. Used by the RTL and by the testbench.
//   prod_w(width)                 full product width (2*width)
//   sum_w(width, stages)          width of the optional chain sum
//   addr_w(stages)                coefficient address width (min 1)
//   stage_latency(k, cas, out)    edges from sampling a_in to prod_valid[k]
package mult_cascade_pkg;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  function automatic int sum_w(input int width, input int stages);
    return (2 * width) + $clog2(stages);
  endfunction

  function automatic int addr_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

  // One edge into stage 0, one per hop, one per inserted cascade register
  // upstream of stage k, plus one if stage k registers its product.
  function automatic int stage_latency(input int k, input logic [31:0] cas_mask,
                                       input logic [31:0] out_mask);
    int lat;
    lat = 1 + k;
    for (int i = 0; i < 32; i++) begin
      lat = lat + (((i < k) && cas_mask[i]) ? 1 : 0);
    end
    lat = lat + (out_mask[k] ? 1 : 0);
    return lat;
  endfunction

endpackage

// File: rtl/mult_cascade_stage.sv
// mult_cascade_stage: one multiplier slice of the cascade chain.
// Holds the A/sign/valid register, its own coefficient, an optional extra
// register on the cascade output and an optional product register.
// Ports:
//   clk, reset (sync, active-high), ce (datapath enable)
//   a_in/valid_in/sign_in      cascade input from the previous stage
//   coef_we/coef_data          coefficient load (not gated by ce)
//   a_out/valid_out/sign_out   cascade output towards the next stage
//   product/prod_valid         2*WIDTH product and its qualifier
//   prod_sign                  signedness of product (only with
//                              MULT_CASCADE_CHAIN_SUM_EN defined)
module mult_cascade_stage
  import mult_cascade_pkg::*;
#(
  parameter int WIDTH   = 18,
  parameter bit CAS_REG = 1'b0,
  parameter bit OUT_REG = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [WIDTH-1:0]          a_in,
  input  logic                      valid_in,
  input  logic                      sign_in,
  input  logic                      coef_we,
  input  logic [WIDTH-1:0]          coef_data,
  output logic [WIDTH-1:0]          a_out,
  output logic                      valid_out,
  output logic                      sign_out,
  output logic [prod_w(WIDTH)-1:0]  product,
  output logic                      prod_valid
`ifdef MULT_CASCADE_CHAIN_SUM_EN
  ,
  output logic                      prod_sign
`endif
);

  localparam int PW = prod_w(WIDTH);

  logic [WIDTH-1:0] a_r;
  logic             valid_r;
  logic             sign_r;
  logic [WIDTH-1:0] coef_r;
  logic [PW-1:0]    a_ext_s;
  logic [PW-1:0]    c_ext_s;
  logic [PW-1:0]    mult_s;

  // Operand register: A, its signedness and its valid travel together
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= '0;
      valid_r <= 1'b0;
      sign_r  <= 1'b0;
    end else if (ce) begin
      a_r     <= a_in;
      valid_r <= valid_in;
      sign_r  <= sign_in;
    end
  end

  // Coefficient register; loads independently of ce
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_r <= '0;
    end else if (coef_we) begin
      coef_r <= coef_data;
    end
  end

  // Extending both operands to 2W and keeping the low 2W bits gives the
  // correct signed or unsigned product from a single multiplier.
  always_comb begin
    a_ext_s = sign_r ? {{WIDTH{a_r[WIDTH-1]}}, a_r}       : {{WIDTH{1'b0}}, a_r};
    c_ext_s = sign_r ? {{WIDTH{coef_r[WIDTH-1]}}, coef_r} : {{WIDTH{1'b0}}, coef_r};
    mult_s  = a_ext_s * c_ext_s;
  end

  if (CAS_REG) begin : g_cas_reg
    logic [WIDTH-1:0] cas_a_r;
    logic             cas_valid_r;
    logic             cas_sign_r;

    // Extra cascade register between this stage and the next
    always_ff @(posedge clk) begin
      if (reset) begin
        cas_a_r     <= '0;
        cas_valid_r <= 1'b0;
        cas_sign_r  <= 1'b0;
      end else if (ce) begin
        cas_a_r     <= a_r;
        cas_valid_r <= valid_r;
        cas_sign_r  <= sign_r;
      end
    end

    assign a_out     = cas_a_r;
    assign valid_out = cas_valid_r;
    assign sign_out  = cas_sign_r;
  end else begin : g_cas_direct
    assign a_out     = a_r;
    assign valid_out = valid_r;
    assign sign_out  = sign_r;
  end

  if (OUT_REG) begin : g_out_reg
    logic [PW-1:0] prod_r;
    logic          prod_valid_r;
    logic          prod_sign_r;

    // Product register; sign is kept alongside for downstream extension
    always_ff @(posedge clk) begin
      if (reset) begin
        prod_r       <= '0;
        prod_valid_r <= 1'b0;
        prod_sign_r  <= 1'b0;
      end else if (ce) begin
        prod_r       <= mult_s;
        prod_valid_r <= valid_r;
        prod_sign_r  <= sign_r;
      end
    end

    assign product    = prod_r;
    assign prod_valid = prod_valid_r;
`ifdef MULT_CASCADE_CHAIN_SUM_EN
    assign prod_sign  = prod_sign_r;
`else
    logic unused_sign_s;
    assign unused_sign_s = prod_sign_r;
`endif
  end else begin : g_out_comb
    assign product    = mult_s;
    assign prod_valid = valid_r;
`ifdef MULT_CASCADE_CHAIN_SUM_EN
    assign prod_sign  = sign_r;
`endif
  end

endmodule

// File: rtl/mult_cascade_chain.sv
// mult_cascade_chain: STAGES multiplier slices sharing one A stream that
// ripples along a cascade path; each slice multiplies by its own
// runtime-loadable coefficient.
// Ports:
//   clk, reset (sync, active-high), ce (datapath/valid enable)
//   a_in/a_valid/a_sign        operand entering stage 0
//   coef_we/coef_addr/coef_data coefficient write port (addr >= STAGES ignored)
//   product                    stage k at [k*2W +: 2W]
//   prod_valid                 per-stage product qualifier
//   cas_a_out/cas_valid_out/cas_sign_out  tail cascade output for chaining
// Optional feature (macro MULT_CASCADE_CHAIN_SUM_EN): adds sum/sum_valid,
// a registered sum of all stage products and the AND of all prod_valid.
module mult_cascade_chain
  import mult_cascade_pkg::*;
#(
  parameter int                WIDTH       = 18,
  parameter int                STAGES      = 5,
  parameter logic [STAGES-1:0] CASCADE_REG = '0,
  parameter logic [STAGES-1:0] OUT_REG     = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic [WIDTH-1:0]                  a_in,
  input  logic                              a_valid,
  input  logic                              a_sign,
  input  logic                              coef_we,
  input  logic [addr_w(STAGES)-1:0]         coef_addr,
  input  logic [WIDTH-1:0]                  coef_data,
  output logic [STAGES*prod_w(WIDTH)-1:0]   product,
  output logic [STAGES-1:0]                 prod_valid,
  output logic [WIDTH-1:0]                  cas_a_out,
  output logic                              cas_valid_out,
  output logic                              cas_sign_out
`ifdef MULT_CASCADE_CHAIN_SUM_EN
  ,
  output logic [sum_w(WIDTH, STAGES)-1:0]   sum,
  output logic                              sum_valid
`endif
);

  localparam int PW = prod_w(WIDTH);
  localparam int AW = addr_w(STAGES);

  // Index k carries the cascade into stage k; index STAGES is the tail.
  logic [WIDTH-1:0] cas_a_s [STAGES+1];
  logic [STAGES:0]  cas_valid_s;
  logic [STAGES:0]  cas_sign_s;
  logic [PW-1:0]    prod_s  [STAGES];
  logic [STAGES-1:0] coef_we_s;

  assign cas_a_s[0]     = a_in;
  assign cas_valid_s[0] = a_valid;
  assign cas_sign_s[0]  = a_sign;

`ifdef MULT_CASCADE_CHAIN_SUM_EN
  logic [STAGES-1:0] prod_sign_s;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign coef_we_s[k] = coef_we && (coef_addr == AW'(k));

    mult_cascade_stage #(
      .WIDTH   (WIDTH),
      .CAS_REG (CASCADE_REG[k]),
      .OUT_REG (OUT_REG[k])
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .a_in       (cas_a_s[k]),
      .valid_in   (cas_valid_s[k]),
      .sign_in    (cas_sign_s[k]),
      .coef_we    (coef_we_s[k]),
      .coef_data  (coef_data),
      .a_out      (cas_a_s[k+1]),
      .valid_out  (cas_valid_s[k+1]),
      .sign_out   (cas_sign_s[k+1]),
      .product    (prod_s[k]),
      .prod_valid (prod_valid[k])
`ifdef MULT_CASCADE_CHAIN_SUM_EN
      ,
      .prod_sign  (prod_sign_s[k])
`endif
    );

    assign product[k*PW +: PW] = prod_s[k];
  end

  assign cas_a_out     = cas_a_s[STAGES];
  assign cas_valid_out = cas_valid_s[STAGES];
  assign cas_sign_out  = cas_sign_s[STAGES];

`ifdef MULT_CASCADE_CHAIN_SUM_EN
  localparam int SW = sum_w(WIDTH, STAGES);

  logic [SW-1:0] sum_s;
  logic [SW-1:0] sum_r;
  logic          sum_valid_r;

  // Adder tree: each product extended according to its own signedness
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (prod_sign_s[k]) begin
        sum_s = sum_s + SW'($signed(prod_s[k]));
      end else begin
        sum_s = sum_s + SW'(prod_s[k]);
      end
    end
  end

  // Registered sum and its qualifier
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r       <= '0;
      sum_valid_r <= 1'b0;
    end else if (ce) begin
      sum_r       <= sum_s;
      sum_valid_r <= &prod_valid;
    end
  end

  assign sum       = sum_r;
  assign sum_valid = sum_valid_r;
`endif

endmodule

// File: tb/tb_mult_cascade_chain.sv
// Self-checking bench for mult_cascade_chain with cascade/output register
// masks set, randomized streams and a sample-history reference model.
module tb_mult_cascade_chain;
  import mult_cascade_pkg::*;

  localparam int W  = 18;
  localparam int S  = 5;
  localparam int PW = 36;
  localparam logic [4:0] CR  = 5'b01010;
  localparam logic [4:0] ORM = 5'b10010;

  logic              clk = 1'b0;
  logic              reset;
  logic              ce;
  logic [W-1:0]      a_in;
  logic              a_valid;
  logic              a_sign;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [W-1:0]      coef_data;
  logic [S*PW-1:0]   product;
  logic [S-1:0]      prod_valid;
  logic [W-1:0]      cas_a_out;
  logic              cas_valid_out;
  logic              cas_sign_out;
`ifdef MULT_CASCADE_CHAIN_SUM_EN
  logic [2*W+2:0]    sum;
  logic              sum_valid;
`endif

  int total = 0;
  int bad   = 0;

  mult_cascade_chain #(
    .WIDTH(W), .STAGES(S), .CASCADE_REG(CR), .OUT_REG(ORM)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .a_in(a_in), .a_valid(a_valid),
    .a_sign(a_sign), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .product(product), .prod_valid(prod_valid),
    .cas_a_out(cas_a_out), .cas_valid_out(cas_valid_out),
    .cas_sign_out(cas_sign_out)
`ifdef MULT_CASCADE_CHAIN_SUM_EN
    , .sum(sum), .sum_valid(sum_valid)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: every sample accepted on a ce edge is logged; stage k
  // shows the sample from la(k) accepted edges ago (one more if registered).
  typedef struct {
    logic [W-1:0] a;
    logic         v;
    logic         s;
  } samp_t;

  samp_t        hist [4096];
  int           n = 0;
  logic [W-1:0] coef_m    [S];
  logic [W-1:0] coef_snap [S];

  function automatic int la(int k);
    int l = 1 + k;
    for (int i = 0; i < k; i++) if (CR[i]) l++;
    return l;
  endfunction

  function automatic samp_t get(int idx);
    samp_t e;
    e.a = '0; e.v = 1'b0; e.s = 1'b0;
    if (idx >= 0) e = hist[idx];
    return e;
  endfunction

  function automatic logic [PW-1:0] mul(logic [W-1:0] a, logic [W-1:0] c, logic s);
    longint x, y, p;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(c));
    end else begin
      x = longint'(a);
      y = longint'(c);
    end
    p = x * y;
    return p[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] exp_prod(int k);
    samp_t e;
    if (ORM[k]) begin
      e = get(n - la(k) - 1);
      return mul(e.a, coef_snap[k], e.s);
    end
    e = get(n - la(k));
    return mul(e.a, coef_m[k], e.s);
  endfunction

  function automatic logic exp_pv(int k);
    samp_t e;
    e = get(n - la(k) - (ORM[k] ? 1 : 0));
    return e.v;
  endfunction

  function automatic samp_t exp_cas();
    return get(n - la(S-1) - (CR[S-1] ? 1 : 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      n = 0;
      for (int k = 0; k < S; k++) begin
        coef_m[k] = '0;
        coef_snap[k] = '0;
      end
    end else begin
      if (ce) begin
        for (int k = 0; k < S; k++) coef_snap[k] = coef_m[k];
        hist[n].a = a_in; hist[n].v = a_valid; hist[n].s = a_sign;
        n++;
      end
      if (coef_we && coef_addr < 3'(S)) coef_m[coef_addr] = coef_data;
    end
    #1;
  endtask

  task automatic write_coef(int addr, logic [W-1:0] data);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_data = data;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; a_in = '0; a_valid = 1'b0; a_sign = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    tick(); tick();
    total++;
    if (product !== '0) begin bad++; $display("FAIL reset_product got=%h exp=0", product); end
    total++;
    if (prod_valid !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=0", prod_valid); end
    total++;
    if ({cas_a_out, cas_valid_out, cas_sign_out} !== '0)
      begin bad++; $display("FAIL reset_cas got=%h exp=0", cas_a_out); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    write_coef(0, 18'h000FD);
    a_in = 18'h12345; a_valid = 1'b1; a_sign = 1'b0;
    tick();
    a_valid = 1'b0; a_in = '0;
    total++;
    if (product[PW-1:0] !== 36'h0011FDB31)
      begin bad++; $display("FAIL single_prod got=%h exp=%h", product[PW-1:0], 36'h0011FDB31); end
    total++;
    if (prod_valid !== 5'b00001)
      begin bad++; $display("FAIL single_valid got=%b exp=00001", prod_valid); end
    tick();
    total++;
    if (prod_valid[0] !== 1'b0)
      begin bad++; $display("FAIL single_valid_drop got=%b exp=0", prod_valid[0]); end
    total++;
    if (product[S*PW-1:PW] !== '0)
      begin bad++; $display("FAIL single_others got=%h exp=0", product[S*PW-1:PW]); end
  endtask

  task automatic test_sign();
    write_coef(0, 18'd3);
    a_in = 18'h3FFFE; a_valid = 1'b1; a_sign = 1'b1;
    tick();
    total++;
    if (product[PW-1:0] !== 36'hFFFFFFFFA)
      begin bad++; $display("FAIL sign_signed got=%h exp=%h", product[PW-1:0], 36'hFFFFFFFFA); end
    a_sign = 1'b0;
    tick();
    total++;
    if (product[PW-1:0] !== 36'h0000BFFFA)
      begin bad++; $display("FAIL sign_unsigned got=%h exp=%h", product[PW-1:0], 36'h0000BFFFA); end
    a_valid = 1'b0;
  endtask

  task automatic test_latency();
    int first [S];
    int lat_exp [S];
    lat_exp = '{1, 3, 4, 5, 8};
    write_coef(0, 18'd2); write_coef(1, 18'd4); write_coef(2, 18'd4);
    write_coef(3, 18'd5); write_coef(4, 18'd6);
    a_valid = 1'b0; a_in = '0;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (prod_valid !== '0) begin bad++; $display("FAIL lat_idle got=%b exp=0", prod_valid); end
    for (int k = 0; k < S; k++) begin
      first[k] = -1;
      total++;
      if (stage_latency(k, 32'(CR), 32'(ORM)) != lat_exp[k])
        begin bad++; $display("FAIL lat_func%0d got=%0d exp=%0d", k, stage_latency(k, 32'(CR), 32'(ORM)), lat_exp[k]); end
    end
    a_in = 18'd4; a_valid = 1'b1; a_sign = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      a_valid = 1'b0; a_in = 18'($urandom);
      for (int k = 0; k < S; k++) begin
        total++;
        if (product[k*PW +: PW] !== exp_prod(k))
          begin bad++; $display("FAIL lat_prod%0d e=%0d got=%h exp=%h", k, e, product[k*PW +: PW], exp_prod(k)); end
        if (prod_valid[k] && first[k] < 0) begin
          first[k] = e;
          if (k == 4) begin
            total++;
            if (product[4*PW +: PW] !== 36'd24)
              begin bad++; $display("FAIL lat_p4 got=%0d exp=24", product[4*PW +: PW]); end
          end
          if (k == 1) begin
            total++;
            if (product[PW +: PW] !== 36'd16)
              begin bad++; $display("FAIL lat_p1 got=%0d exp=16", product[PW +: PW]); end
          end
        end
      end
    end
    for (int k = 0; k < S; k++) begin
      total++;
      if (first[k] != lat_exp[k])
        begin bad++; $display("FAIL lat_edge%0d got=%0d exp=%0d", k, first[k], lat_exp[k]); end
    end
  endtask

  task automatic test_random();
    samp_t ec;
    for (int t = 0; t < 300; t++) begin
      ce      = ($urandom_range(0, 7) != 0);
      a_in    = 18'($urandom);
      a_valid = 1'($urandom);
      a_sign  = 1'($urandom);
      coef_we = ($urandom_range(0, 3) == 0);
      coef_addr = 3'($urandom_range(0, 7));
      coef_data = 18'($urandom);
      tick();
      for (int k = 0; k < S; k++) begin
        total++;
        if (product[k*PW +: PW] !== exp_prod(k))
          begin bad++; $display("FAIL rand_prod%0d t=%0d got=%h exp=%h", k, t, product[k*PW +: PW], exp_prod(k)); end
        total++;
        if (prod_valid[k] !== exp_pv(k))
          begin bad++; $display("FAIL rand_valid%0d t=%0d got=%b exp=%b", k, t, prod_valid[k], exp_pv(k)); end
      end
      ec = exp_cas();
      total++;
      if ({cas_a_out, cas_valid_out, cas_sign_out} !== {ec.a, ec.v, ec.s})
        begin bad++; $display("FAIL rand_cas t=%0d got=%h/%b/%b exp=%h/%b/%b", t, cas_a_out, cas_valid_out, cas_sign_out, ec.a, ec.v, ec.s); end
    end
    coef_we = 1'b0; ce = 1'b1;
  endtask

  task automatic test_ce_hold();
    logic [S*PW-1:0] p_snap;
    logic [S-1:0]    v_snap;
    logic [W+1:0]    c_snap;
    for (int k = 0; k < S; k++) write_coef(k, 18'($urandom_range(1, 1000)));
    for (int i = 0; i < 12; i++) begin
      a_in = 18'($urandom); a_valid = 1'($urandom); a_sign = 1'b0;
      tick();
    end
    p_snap = product; v_snap = prod_valid;
    c_snap = {cas_a_out, cas_valid_out, cas_sign_out};
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in = 18'($urandom); a_valid = 1'b1;
      coef_we = (i == 0); coef_addr = 3'd7; coef_data = 18'h3FFFF;
      tick();
      coef_we = 1'b0;
      total++;
      if (product !== p_snap) begin bad++; $display("FAIL hold_prod i=%0d got=%h exp=%h", i, product, p_snap); end
      total++;
      if (prod_valid !== v_snap) begin bad++; $display("FAIL hold_valid i=%0d got=%b exp=%b", i, prod_valid, v_snap); end
      total++;
      if ({cas_a_out, cas_valid_out, cas_sign_out} !== c_snap)
        begin bad++; $display("FAIL hold_cas i=%0d got=%h exp=%h", i, {cas_a_out, cas_valid_out, cas_sign_out}, c_snap); end
    end
    ce = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_in = 18'($urandom); a_valid = 1'($urandom);
      tick();
      for (int k = 0; k < S; k++) begin
        total++;
        if (product[k*PW +: PW] !== exp_prod(k) || prod_valid[k] !== exp_pv(k))
          begin bad++; $display("FAIL resume_stage%0d i=%0d got=%h/%b exp=%h/%b", k, i, product[k*PW +: PW], prod_valid[k], exp_prod(k), exp_pv(k)); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) begin
      a_in = 18'($urandom); a_valid = 1'b1;
      tick();
    end
    reset = 1'b1; coef_we = 1'b1; coef_addr = 3'd0; coef_data = 18'd9;
    tick();
    reset = 1'b0; coef_we = 1'b0;
    total++;
    if (product !== '0 || prod_valid !== '0)
      begin bad++; $display("FAIL midrst_clear got=%h/%b exp=0/0", product, prod_valid); end
    a_in = 18'd5; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    total++;
    if (prod_valid !== 5'b00001)
      begin bad++; $display("FAIL midrst_restart_valid got=%b exp=00001", prod_valid); end
    total++;
    if (product[PW-1:0] !== '0)
      begin bad++; $display("FAIL midrst_coef_cleared got=%h exp=0", product[PW-1:0]); end
    for (int i = 0; i < 10; i++) begin
      tick();
      for (int k = 0; k < S; k++) begin
        total++;
        if (prod_valid[k] !== exp_pv(k))
          begin bad++; $display("FAIL midrst_valid%0d i=%0d got=%b exp=%b", k, i, prod_valid[k], exp_pv(k)); end
      end
    end
  endtask

`ifdef MULT_CASCADE_CHAIN_SUM_EN
  task automatic test_sum();
    for (int k = 0; k < S; k++) write_coef(k, 18'd2);
    a_in = 18'd3; a_valid = 1'b1; a_sign = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (sum !== 39'd30) begin bad++; $display("FAIL sum_value got=%0d exp=30", sum); end
    total++;
    if (sum_valid !== 1'b1) begin bad++; $display("FAIL sum_valid got=%b exp=1", sum_valid); end
    a_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_sign();
    test_latency();
    test_random();
    test_ce_hold();
    test_reset_midstream();
`ifdef MULT_CASCADE_CHAIN_SUM_EN
    test_sum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_cascade_chain.md
Name: mult_cascade_chain

Overview:
- Parametrised successor to hand-instantiated MULT18X18 chains in the DSP examples.
- One operand stream (A) ripples through STAGES multiplier stages via a cascade path, the SOA/SIA equivalent.
- Each stage multiplies the arriving A by its own runtime-loadable coefficient.
- Adds valid tracking, per-stage cascade/output register selection, runtime signedness, a coefficient write port, and a tail cascade output so chains can be concatenated.

Parameters:
- WIDTH, 18, operand width of A and coefficients.
- STAGES, 5, number of multiplier stages (>=1).
- CASCADE_REG, 0, STAGES-bit mask; bit k=1 inserts an extra register on stage k's cascade output (SOA_REG).
- OUT_REG, 0, STAGES-bit mask; bit k=1 registers stage k's product.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable for all datapath/valid registers; does not gate coefficient writes
- a_in  in  WIDTH  operand entering stage 0
- a_valid  in  1  a_in qualifier
- a_sign  in  1  1 = treat A and coefficient as two's complement; travels with its A
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(STAGES) (min 1)  target stage
- coef_data  in  WIDTH  coefficient value
- product  out  STAGES*2*WIDTH  stage k occupies bits [k*2W +: 2W]
- prod_valid  out  STAGES  per-stage product qualifier
- cas_a_out / cas_valid_out / cas_sign_out  out  WIDTH/1/1  last stage's cascade output

Behaviour:
- Reset (synchronous, active-high) clears all A/sign/valid registers, cascade registers, output registers and all coefficients to 0. All outputs read 0 the cycle after reset is sampled. Reset wins over ce and coef_we.
- Stage 0 A register (always present) loads a_in/a_valid/a_sign on a clock edge with ce=1.
- Stage k>0 A register loads stage k-1's cascade output: the A register directly, or the extra cascade register if CASCADE_REG[k-1]=1.
- Latency from the sampling edge to stage k A register valid: 1 + k + popcount(CASCADE_REG[k-1:0]) edges.
- Product: a_reg_k × coef_k, full 2W result.
  - a_sign=1: both operands sign-extended, signed product.
  - a_sign=0: unsigned.
  - OUT_REG[k]=0: combinational from a_reg_k, prod_valid[k]=valid_k.
  - OUT_REG[k]=1: one extra edge for both product and valid.
- Invalid slots still propagate A values. Product is computed regardless; prod_valid is the only qualifier.
- ce=0 freezes every datapath/valid register. Combinational products track coefficient changes.
- Coefficient write: coef_k updates on the edge where coef_we=1. It affects product from the next cycle, including in-flight data. coef_addr>=STAGES is ignored.
- cas_* outputs equal the last stage's cascade output (after its optional CASCADE_REG).
- Reset mid-stream discards all in-flight data; no partial valid survives.

Optional Feature:
- Macro: MULT_CASCADE_CHAIN_SUM_EN
- When defined, adds ports sum (2*WIDTH+$clog2(STAGES)) and sum_valid.
  - sum is the registered sum of all stage products, each sign- or zero-extended per its own sign bit.
  - sum_valid = registered AND of all prod_valid bits. It is held by ce and cleared by reset.
- When undefined, the ports and adder are absent. All other behaviour is identical.

Decomposition:
- Shared package mult_cascade_pkg:
  - function prod_w(WIDTH)=2*WIDTH
  - sum-width function
  - latency function stage_latency(k, CASCADE_REG, OUT_REG), shared by RTL and bench
- Sub-module mult_cascade_stage: A/sign/valid register, optional cascade register, multiplier, optional output register. Instantiated STAGES times with a generate loop.

Test Plan:
1. Defaults; coef0=0xFD; a_in=0x12345, a_valid=1, a_sign=0 for one cycle -> product[0]=0x11FDB31, prod_valid[0]=1 exactly one cycle, 1 edge after sampling; other stages read 0 until A arrives.
2. STAGES=5, CASCADE_REG=5'b01010, OUT_REG=5'b10010, coef={6,5,4,4,2}, a_in=4 -> product[4]=24, valid 8 edges after sampling; product[1]=16, valid 3 edges after; others match stage_latency.
3. coef0=3, a_in=0x3FFFE -> a_sign=1 gives product[0]=0xFFFFFFFFA (-6); a_sign=0 gives 0xBFFFA.
4. ce low for 3 cycles mid-stream -> all products/valids hold, stream resumes unchanged; coef_addr=7 with STAGES=5 -> no coefficient changes.
5. Reset asserted while valids are in flight -> next cycle all prod_valid=0, product=0, coefficients=0; stream restarts cleanly.
6. With MULT_CASCADE_CHAIN_SUM_EN, coef all 2, a_in=3 held valid -> steady-state sum=30 (STAGES=5), sum_valid=1.
